// File: rtl/reorg_copy_engine_if.sv
// reorg_copy_engine_if: scheduler handshake plus source/destination memory ports.
// master = copy engine side, slave = scheduler/memory side.
interface reorg_copy_engine_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] des_base;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (
    input  start, src_base, des_base, rd_data, wr_ready,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, src_base, des_base, rd_data, wr_ready,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/reorg_copy_engine.sv
// reorg_copy_engine: YOLO reorg (space-to-depth) layer copy sequencer.
// Optional REORG_CHECKSUM_EN adds a 32-bit write-data checksum output.
module reorg_copy_engine #(
  parameter int WIDTH      = 12,
  parameter int HEIGHT     = 12,
  parameter int DEPTH_SRC  = 64,
  parameter int WIDTH_SRC  = 24,
  parameter int HEIGHT_SRC = 24,
  parameter int STRIDE     = 2,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  reorg_copy_engine_if.master bus
`ifdef REORG_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam int LS = $clog2(STRIDE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CW-1:0]     cnt_t;

  localparam addr_t W_A  = addr_t'(WIDTH);
  localparam addr_t H_A  = addr_t'(HEIGHT);
  localparam addr_t D_A  = addr_t'(DEPTH_SRC);
  localparam addr_t WS_A = addr_t'(WIDTH_SRC);
  localparam addr_t HS_A = addr_t'(HEIGHT_SRC);
  localparam addr_t S_A  = addr_t'(STRIDE);
  localparam addr_t SM_A = addr_t'(STRIDE - 1);
  localparam addr_t W_M  = addr_t'(WIDTH - 1);
  localparam addr_t H_M  = addr_t'(HEIGHT - 1);
  localparam addr_t D_M  = addr_t'(DEPTH_SRC - 1);
  localparam addr_t O_M  = addr_t'(STRIDE * STRIDE - 1);
  localparam cnt_t  FD_C = cnt_t'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  addr_t col_q, col_d;
  addr_t row_q, row_d;
  addr_t chs_q, chs_d;
  addr_t off_q, off_d;
  addr_t sbase_q, sbase_d;
  addr_t dbase_q, dbase_d;
  logic  rd_en_q, rd_en_d;
  addr_t rd_addr_q, rd_addr_d;
  addr_t wa_q, wa_d;
  logic [RD_LAT-1:0] pv_q, pv_d;
  addr_t pa_q [RD_LAT];
  addr_t pa_d [RD_LAT];
  addr_t fa_q [FIFO_DEPTH];
  addr_t fa_d [FIFO_DEPTH];
  data_t fd_q [FIFO_DEPTH];
  data_t fd_d [FIFO_DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  cnt_t cnt_q, cnt_d;

  logic  wr_en, push, pop, last, issue, room, start_acc;
  cnt_t  inflight;
  addr_t sb, db, src_a, dst_a;

  assign wr_en       = (cnt_q != '0);
  assign push        = pv_q[RD_LAT-1];
  assign pop         = wr_en & bus.wr_ready;
  assign start_acc   = (state_q == S_IDLE) & bus.start;

  assign bus.busy    = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign bus.done    = (state_q == S_DONE);
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = fa_q[head_q];
  assign bus.wr_data = fd_q[head_q];

  // Source/destination address of the element the counters point at.
  always_comb begin
    sb = (state_q == S_IDLE) ? bus.src_base : sbase_q;
    db = (state_q == S_IDLE) ? bus.des_base : dbase_q;
    src_a = sb + col_q * S_A + (off_q & SM_A)
          + WS_A * (row_q * S_A + (off_q >> LS) + chs_q * HS_A);
    dst_a = db + col_q
          + W_A * (row_q + (off_q * D_A + chs_q) * H_A);
    last = (col_q == W_M) && (row_q == H_M)
        && (chs_q == D_M) && (off_q == O_M);
  end

  // Read delay line, write FIFO, credit check and sequencer FSM.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    chs_d     = chs_q;
    off_d     = off_q;
    sbase_d   = sbase_q;
    dbase_d   = dbase_q;
    rd_addr_d = rd_addr_q;
    wa_d      = wa_q;
    rd_en_d   = 1'b0;
    issue     = 1'b0;
    fa_d      = fa_q;
    fd_d      = fd_q;
    head_d    = head_q;
    tail_d    = tail_q;

    pv_d[0] = rd_en_q;
    pa_d[0] = wa_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
    end

    if (push) begin
      fa_d[tail_q] = pa_q[RD_LAT-1];
      fd_d[tail_q] = bus.rd_data;
      tail_d       = tail_q + 1'b1;
    end
    if (pop) head_d = head_q + 1'b1;
    cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);

    // reads still to land after this edge; the one pushing now is in cnt_d
    inflight = cnt_t'(rd_en_q);
    for (int i = 0; i < RD_LAT - 1; i++) begin
      inflight = inflight + cnt_t'(pv_q[i]);
    end
    room = (cnt_d + inflight) < FD_C;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sbase_d = bus.src_base;
          dbase_d = bus.des_base;
          issue   = 1'b1;
          state_d = last ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (room) begin
          issue = 1'b1;
          if (last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_d == '0 && inflight == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      rd_en_d   = 1'b1;
      rd_addr_d = src_a;
      wa_d      = dst_a;
      if (col_q == W_M) begin
        col_d = '0;
        if (row_q == H_M) begin
          row_d = '0;
          if (chs_q == D_M) begin
            chs_d = '0;
            off_d = (off_q == O_M) ? '0 : off_q + 1'b1;
          end else begin
            chs_d = chs_q + 1'b1;
          end
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // State, counters, delay line and FIFO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      chs_q     <= '0;
      off_q     <= '0;
      sbase_q   <= '0;
      dbase_q   <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wa_q      <= '0;
      pv_q      <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < RD_LAT; i++) pa_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fa_q[i] <= '0;
        fd_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      chs_q     <= chs_d;
      off_q     <= off_d;
      sbase_q   <= sbase_d;
      dbase_q   <= dbase_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wa_q      <= wa_d;
      pv_q      <= pv_d;
      pa_q      <= pa_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      fa_q      <= fa_d;
      fd_q      <= fd_d;
    end
  end

`ifdef REORG_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  assign checksum = sum_q;

  // Running sum of accepted write data, restarted per transfer.
  always_comb begin
    sum_d = sum_q;
    if (start_acc) sum_d = '0;
    else if (pop) sum_d = sum_q + 32'(fd_q[head_q]);
  end

  // Checksum register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else sum_q <= sum_d;
  end
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_reorg_copy_engine.sv
// tb_reorg_copy_engine: directed test of the reorg copy engine.
// Two instances: RD_LAT=1/FIFO 4 and RD_LAT=4/FIFO 8, 2x2x1 stride-2 layer.
module tb_reorg_copy_engine;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  reorg_copy_engine_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
  reorg_copy_engine_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

`ifdef REORG_CHECKSUM_EN
  logic [31:0] csum0, csum1;
`endif

  reorg_copy_engine #(
    .WIDTH(2), .HEIGHT(2), .DEPTH_SRC(1),
    .WIDTH_SRC(4), .HEIGHT_SRC(4), .STRIDE(2),
    .ADDR_W(16), .DATA_W(16), .RD_LAT(1), .FIFO_DEPTH(4)
  ) u0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
`ifdef REORG_CHECKSUM_EN
    , .checksum(csum0)
`endif
  );

  reorg_copy_engine #(
    .WIDTH(2), .HEIGHT(2), .DEPTH_SRC(1),
    .WIDTH_SRC(4), .HEIGHT_SRC(4), .STRIDE(2),
    .ADDR_W(16), .DATA_W(16), .RD_LAT(4), .FIFO_DEPTH(8)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
`ifdef REORG_CHECKSUM_EN
    , .checksum(csum1)
`endif
  );

  // source memories: src[a] = a + 1, garbage when no read is due
  always @(posedge clk)
    bus0.rd_data <= bus0.rd_en ? bus0.rd_addr + 16'd1 : 16'hDEAD;

  logic [15:0] d1 [4];
  always @(posedge clk) begin
    d1[0] <= bus1.rd_en ? bus1.rd_addr + 16'd1 : 16'hDEAD;
    d1[1] <= d1[0];
    d1[2] <= d1[1];
    d1[3] <= d1[2];
  end
  assign bus1.rd_data = d1[3];

  logic [15:0] ra0[$];
  logic [15:0] wa0[$];
  logic [15:0] wd0[$];
  logic [15:0] wa1[$];
  logic [15:0] wd1[$];
  int nrd1, dcnt0, occ_max0, stall_err, occ;
  logic stall_p;
  logic [15:0] stall_a, stall_d;

  // monitors sample mid-cycle; inputs only change just after posedge
  always @(negedge clk) begin
    if (bus0.rd_en) ra0.push_back(bus0.rd_addr);
    occ = ra0.size() - wa0.size();
    if (occ > occ_max0) occ_max0 = occ;
    if (stall_p && (!bus0.wr_en || bus0.wr_addr !== stall_a
        || bus0.wr_data !== stall_d)) stall_err++;
    stall_p = bus0.wr_en && !bus0.wr_ready;
    stall_a = bus0.wr_addr;
    stall_d = bus0.wr_data;
    if (bus0.wr_en && bus0.wr_ready) begin
      wa0.push_back(bus0.wr_addr);
      wd0.push_back(bus0.wr_data);
    end
    if (bus0.done) dcnt0++;
    if (bus1.rd_en) nrd1++;
    if (bus1.wr_en && bus1.wr_ready) begin
      wa1.push_back(bus1.wr_addr);
      wd1.push_back(bus1.wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // destination element d of the 2x2x4 output maps to this source word
  function automatic logic [15:0] exp_data(input logic [15:0] sb, input int d);
    int col, row, ch, off, cs, rs, ci;
    col = d % 2;
    row = (d / 2) % 2;
    ch  = d / 4;
    off = ch / 1;
    ci  = ch % 1;
    cs  = col * 2 + off % 2;
    rs  = row * 2 + off / 2;
    return sb + 16'(cs + 4 * (rs + ci * 4)) + 16'd1;
  endfunction

  task automatic check_writes(input int which, input logic [15:0] sb,
                              input logic [15:0] db, input string tag);
    int n;
    n = (which == 1) ? wa1.size() : wa0.size();
    chk({tag, "_nwr"}, 32'(n), 32'd16);
    for (int i = 0; i < 16 && i < n; i++) begin
      if (which == 1) begin
        chk({tag, "_waddr"}, 32'(wa1[i]), 32'(db + 16'(i)));
        chk({tag, "_wdata"}, 32'(wd1[i]), 32'(exp_data(sb, i)));
      end else begin
        chk({tag, "_waddr"}, 32'(wa0[i]), 32'(db + 16'(i)));
        chk({tag, "_wdata"}, 32'(wd0[i]), 32'(exp_data(sb, i)));
      end
    end
  endtask

  task automatic run0(input logic [15:0] sb, input logic [15:0] db,
                      input int mode, input bit poke, output int lat);
    ra0.delete();
    wa0.delete();
    wd0.delete();
    dcnt0 = 0;
    occ_max0 = 0;
    stall_err = 0;
    stall_p = 1'b0;
    @(posedge clk); #1;
    bus0.src_base = sb;
    bus0.des_base = db;
    bus0.wr_ready = 1'b1;
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    @(negedge clk); #1;
    chk("k0_busy", 32'(bus0.busy), 32'd1);
    chk("k0_rd_en", 32'(bus0.rd_en), 32'd1);
    chk("k0_rd_addr", 32'(bus0.rd_addr), 32'(sb));
    lat = 0;
    while (!bus0.done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (mode == 1) bus0.wr_ready = (lat % 4 == 0) || (lat % 4 == 3);
      if (poke) begin
        bus0.start = (lat == 5);
        if (lat == 5) begin
          bus0.src_base = 16'h300;
          bus0.des_base = 16'h380;
        end
      end
      @(negedge clk); #1;
    end
    chk("done_seen", 32'(bus0.done), 32'd1);
    @(posedge clk); #1;
    bus0.wr_ready = 1'b1;
    @(negedge clk); #1;
    chk("done_single", 32'(bus0.done), 32'd0);
    chk("busy_after", 32'(bus0.busy), 32'd0);
  endtask

  logic [15:0] exp5 [5] = '{16'd0, 16'd2, 16'd8, 16'd10, 16'd1};
  int lat;

  initial begin
    bus0.start = 1'b0;
    bus0.src_base = '0;
    bus0.des_base = '0;
    bus0.wr_ready = 1'b1;
    bus1.start = 1'b0;
    bus1.src_base = '0;
    bus1.des_base = '0;
    bus1.wr_ready = 1'b1;
    stall_p = 1'b0;
    nrd1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_done", 32'(bus0.done), 32'd0);
    chk("rst_rd_en", 32'(bus0.rd_en), 32'd0);
    chk("rst_wr_en", 32'(bus0.wr_en), 32'd0);
    chk("rst_rd_addr", 32'(bus0.rd_addr), 32'd0);
    chk("rst_wr_addr", 32'(bus0.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus0.wr_data), 32'd0);
    chk("rst_busy1", 32'(bus1.busy), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // plain transfer, bases 0
    run0(16'h0, 16'h0, 0, 1'b0, lat);
    chk("t1_lat", 32'(lat), 32'd18);
    chk("t1_nrd", 32'(ra0.size()), 32'd16);
    for (int i = 0; i < 5 && i < ra0.size(); i++)
      chk("t1_rd_addr", 32'(ra0[i]), 32'(exp5[i]));
    check_writes(0, 16'h0, 16'h0, "t1");
    chk("t1_dones", 32'(dcnt0), 32'd1);
`ifdef REORG_CHECKSUM_EN
    chk("t1_csum", csum0, 32'd136);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("t1_csum_hold", csum0, 32'd136);
`endif

    // offset bases, plus a start while busy that must be ignored
    run0(16'h100, 16'h200, 0, 1'b1, lat);
    chk("t2_lat", 32'(lat), 32'd18);
    check_writes(0, 16'h100, 16'h200, "t2");
    if (ra0.size() > 4) begin
      chk("t2_rd0", 32'(ra0[0]), 32'h100);
      chk("t2_rd4", 32'(ra0[4]), 32'h101);
    end
    if (wa0.size() > 4) begin
      chk("t2_w204_addr", 32'(wa0[4]), 32'h204);
      chk("t2_w204_data", 32'(wd0[4]), 32'h102);
    end
    repeat (30) @(posedge clk);
    @(negedge clk); #1;
    chk("t2_no_restart", 32'(dcnt0), 32'd1);
    chk("t2_idle", 32'(bus0.busy), 32'd0);

    // wr_ready toggling 1,0,0,1
    run0(16'h0, 16'h0, 1, 1'b0, lat);
    check_writes(0, 16'h0, 16'h0, "t3");
    chk("t3_stalled", 32'(lat > 18), 32'd1);
    chk("t3_stable", 32'(stall_err), 32'd0);
    chk("t3_occ", 32'(occ_max0 <= 4), 32'd1);
    chk("t3_dones", 32'(dcnt0), 32'd1);

    // RD_LAT=4, FIFO 8, writes blocked for 20 cycles
    wa1.delete();
    wd1.delete();
    nrd1 = 0;
    @(posedge clk); #1;
    bus1.wr_ready = 1'b0;
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    chk("t4_reads", 32'(nrd1), 32'd8);
    chk("t4_rd_hold", 32'(bus1.rd_en), 32'd0);
    chk("t4_no_wr", 32'(wa1.size()), 32'd0);
    @(posedge clk); #1;
    bus1.wr_ready = 1'b1;
    for (int i = 0; i < 200 && !bus1.done; i++) begin
      @(posedge clk);
      @(negedge clk); #1;
    end
    chk("t4_done", 32'(bus1.done), 32'd1);
    chk("t4_nrd", 32'(nrd1), 32'd16);
    check_writes(1, 16'h0, 16'h0, "t4");

    // reset mid-RUN, then a fresh transfer
    @(posedge clk); #1;
    bus0.src_base = '0;
    bus0.des_base = '0;
    bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk); #1;
    chk("t5_busy", 32'(bus0.busy), 32'd0);
    chk("t5_rd_en", 32'(bus0.rd_en), 32'd0);
    chk("t5_wr_en", 32'(bus0.wr_en), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run0(16'h40, 16'h80, 0, 1'b0, lat);
    chk("t5_lat", 32'(lat), 32'd18);
    check_writes(0, 16'h40, 16'h80, "t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
